// File: rtl/serial_bit_tx_pkg.sv
// Shared definitions for the serial bit transmitter: FSM state encoding and a
// ceiling-log2 helper used to size counters.
package serial_bit_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Number of bits needed to hold values 0..n-1 (0 for n <= 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_bit_tx_bit_timer.sv
// Per-bit cycle counter: ticks on the last cycle of each serial bit and wraps.
module serial_bit_tx_bit_timer
    import serial_bit_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned CNT_W = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign tick_c = (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || tick_c) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_bit_tx.sv
// Serial transmitter: accepts a word on valid/ready and sends
// start(0), WIDTH data bits LSB first, stop(1), each held CLKS_PER_BIT cycles.
module serial_bit_tx
    import serial_bit_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] Din,
    input  logic             valid,
    output logic             ready,
    output logic             Aout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BIT_W = (clog2(WIDTH + 1) < 1) ? 1 : clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    tx_state_e        state, state_d;
    logic [WIDTH-1:0] shift, shift_d;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
    logic             aout_d, ready_d, busy_d, done_d;
    logic             tick_c;

    serial_bit_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (state == IDLE),
        .tick_c (tick_c)
    );

    // Next-state logic; outputs are decoded from the next state so the
    // registered copies line up with the state they describe.
    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_cnt_d = bit_cnt;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                if (valid && ready) begin
                    state_d   = START;
                    shift_d   = Din;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (tick_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick_c) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_d   = STOP;
                        bit_cnt_d = '0;
                    end else begin
                        shift_d   = shift >> 1;
                        bit_cnt_d = bit_cnt + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick_c) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        aout_d  = (state_d == START) ? 1'b0 :
                  (state_d == DATA)  ? shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            Aout    <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            bit_cnt <= bit_cnt_d;
            Aout    <= aout_d;
            ready   <= ready_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench for serial_bit_tx: two instances (8 bits/4 clks, 4 bits/1 clk)
// with per-cycle expected line/busy/done values queued when a word is accepted.
module tb_serial_bit_tx;

    typedef struct packed {
        logic aout;
        logic busy;
        logic done;
    } exp_t;

    localparam exp_t IDLE_E = '{aout: 1'b1, busy: 1'b0, done: 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [7:0] din0;
    logic       valid0, ready0, aout0, busy0, done0;
    logic [3:0] din1;
    logic       valid1, ready1, aout1, busy1, done1;

    int checks   = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    serial_bit_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .Din(din0), .valid(valid0),
        .ready(ready0), .Aout(aout0), .busy(busy0), .done(done0)
    );

    serial_bit_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .Din(din1), .valid(valid1),
        .ready(ready1), .Aout(aout1), .busy(busy1), .done(done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected per-cycle line for one frame, followed by the done cycle.
    task automatic push_frame(input int which, input logic [7:0] data, input int w, input int cpb);
        exp_t e;
        for (int b = 0; b < w + 2; b++) begin
            logic bitv;
            bitv = (b == 0) ? 1'b0 : (b == w + 1) ? 1'b1 : data[b-1];
            for (int c = 0; c < cpb; c++) begin
                e = '{aout: bitv, busy: 1'b1, done: 1'b0};
                if (which == 0) q0.push_back(e);
                else            q1.push_back(e);
            end
        end
        e = '{aout: 1'b1, busy: 1'b0, done: 1'b1};
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            q0.delete();
            e = IDLE_E;
        end else if (q0.size() > 0) begin
            e = q0.pop_front();
        end else begin
            e = IDLE_E;
        end
        check_eq("aout0",  32'(aout0),  32'(e.aout));
        check_eq("busy0",  32'(busy0),  32'(e.busy));
        check_eq("ready0", 32'(ready0), 32'(!e.busy));
        check_eq("done0",  32'(done0),  32'(e.done));
        if (reset_n && !e.busy && valid0) push_frame(0, din0, 8, 4);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            q1.delete();
            e = IDLE_E;
        end else if (q1.size() > 0) begin
            e = q1.pop_front();
        end else begin
            e = IDLE_E;
        end
        check_eq("aout1",  32'(aout1),  32'(e.aout));
        check_eq("busy1",  32'(busy1),  32'(e.busy));
        check_eq("ready1", 32'(ready1), 32'(!e.busy));
        check_eq("done1",  32'(done1),  32'(e.done));
        if (reset_n && !e.busy && valid1) push_frame(1, {4'b0000, din1}, 4, 1);
    end

    initial begin
        reset_n = 1'b0;
        din0    = 8'h00;
        valid0  = 1'b0;
        din1    = 4'h0;
        valid1  = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (20) @(posedge clk);

        // Single 8'hA5 frame, with an ignored 8'hFF request while busy
        #1 din0 = 8'hA5; valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0;
        repeat (8) @(posedge clk);
        #1 din0 = 8'hFF; valid0 = 1'b1;
        repeat (5) @(posedge clk);
        #1 valid0 = 1'b0; din0 = 8'h00;
        repeat (40) @(posedge clk);

        // Back-to-back: 8'h01 then 8'h80 accepted in the done cycle
        #1 din0 = 8'h01; valid0 = 1'b1;
        @(posedge clk);
        #1 din0 = 8'h80;
        repeat (41) @(posedge clk);
        #1 valid0 = 1'b0;
        repeat (45) @(posedge clk);

        // Asynchronous reset during data bit 3 of 8'h3C
        #1 din0 = 8'h3C; valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0;
        repeat (17) @(posedge clk);
        #1 check_eq("busy_before_rst", 32'(busy0), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_aout",  32'(aout0),  32'd1);
        check_eq("rst_ready", 32'(ready0), 32'd1);
        check_eq("rst_busy",  32'(busy0),  32'd0);
        check_eq("rst_done",  32'(done0),  32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 din0 = 8'h3C; valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0;
        repeat (45) @(posedge clk);

        // One clock per bit: 4'b1001, then 4'b0110 twice back-to-back
        #1 din1 = 4'b1001; valid1 = 1'b1;
        @(posedge clk);
        #1 valid1 = 1'b0;
        repeat (10) @(posedge clk);
        #1 din1 = 4'b0110; valid1 = 1'b1;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1 valid1 = 1'b0;
        repeat (12) @(posedge clk);

        check_eq("q0_drained", 32'(q0.size()), 32'd0);
        check_eq("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
